// File: rtl/modn_counter_pkg.sv
// rtl/modn_counter_pkg.sv - shared state type and load clamp for the modulo-N down counter
package modn_counter_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  // Values at or above the modulus are pinned to the largest legal count.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] mod);
    return (val >= mod) ? (mod - 32'd1) : val;
  endfunction

endpackage

// File: rtl/modn_down_counter.sv
// rtl/modn_down_counter.sv - modulo-N down counter with free-run and one-shot modes
module modn_down_counter #(
  parameter  int MOD   = 4,
  localparam int WIDTH = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  import modn_counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  cnt_state_t       state;
  cnt_state_t       next_state;
  logic [WIDTH-1:0] next_count;

  // Terminal count fires on the enabled cycle that sees zero, except once stopped.
  assign tc = en && (count == '0) && (state != DONE);

  // Next state/count: load wins over en, and a loaded value is not decremented.
  always_comb begin
    next_state = state;
    next_count = count;
    if (load) begin
      next_count = WIDTH'(clamp_load(32'(load_val), 32'(MOD)));
      next_state = oneshot ? RUN : FREE;
    end else if (en) begin
      case (state)
        FREE: next_count = (count == '0) ? MAX : (count - WIDTH'(1));
        RUN: begin
          if (count == '0) begin
            next_state = DONE;
          end else begin
            next_count = count - WIDTH'(1);
          end
        end
        DONE: next_count = count;
        default: begin
          next_state = FREE;
          next_count = MAX;
        end
      endcase
    end
  end

  // Register state, count and the state-decoded flags; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FREE;
      count <= MAX;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      done  <= (next_state == DONE);
      busy  <= (next_state == RUN);
    end
  end

endmodule

// File: tb/tb_modn_down_counter.sv
// tb/tb_modn_down_counter.sv - randomized reference-model bench for modn_down_counter
module tb_modn_down_counter;

  localparam int MOD_A = 4;
  localparam int MOD_B = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       oneshot = 1'b0;
  logic [1:0] load_val_a = '0;
  logic [2:0] load_val_b = '0;
  logic [1:0] count_a;
  logic [2:0] count_b;
  logic       tc_a, done_a, busy_a;
  logic       tc_b, done_b, busy_b;

  int total = 0;
  int bad = 0;

  // Reference: mode 0 = free, 1 = one-shot running, 2 = finished.
  int  m_cnt[2];
  int  m_mode[2];
  int  m_mod[2];
  bit  m_init = 0;

  always #5 clk = ~clk;

  modn_down_counter #(.MOD(MOD_A)) dut_a (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val_a),
    .oneshot(oneshot), .count(count_a), .tc(tc_a), .done(done_a), .busy(busy_a)
  );

  modn_down_counter #(.MOD(MOD_B)) dut_b (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val_b),
    .oneshot(oneshot), .count(count_b), .tc(tc_b), .done(done_b), .busy(busy_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i, input bit rst, input bit e, input bit ld,
                            input int val, input bit os);
    if (!rst) begin
      m_cnt[i]  = m_mod[i] - 1;
      m_mode[i] = 0;
    end else if (ld) begin
      m_cnt[i]  = (val >= m_mod[i]) ? m_mod[i] - 1 : val;
      m_mode[i] = os ? 1 : 0;
    end else if (e) begin
      if (m_mode[i] == 0) begin
        m_cnt[i] = (m_cnt[i] + m_mod[i] - 1) % m_mod[i];
      end else if (m_mode[i] == 1) begin
        if (m_cnt[i] == 0) m_mode[i] = 2;
        else m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endtask

  // One clock: drive at negedge, check tc before the edge, registered outputs after it.
  task automatic step(input bit rst, input bit e, input bit ld, input int val, input bit os);
    @(negedge clk);
    reset      = rst;
    en         = e;
    load       = ld;
    oneshot    = os;
    load_val_a = val[1:0];
    load_val_b = val[2:0];
    #1;
    if (m_init) begin
      check("tc_a", int'(tc_a), int'(e && m_cnt[0] == 0 && m_mode[0] != 2));
      check("tc_b", int'(tc_b), int'(e && m_cnt[1] == 0 && m_mode[1] != 2));
    end
    @(posedge clk);
    model_edge(0, rst, e, ld, val % 4, os);
    model_edge(1, rst, e, ld, val % 8, os);
    if (!rst) m_init = 1;
    #1;
    if (m_init) begin
      check("count_a", int'(count_a), m_cnt[0]);
      check("done_a",  int'(done_a),  int'(m_mode[0] == 2));
      check("busy_a",  int'(busy_a),  int'(m_mode[0] == 1));
      check("count_b", int'(count_b), m_cnt[1]);
      check("done_b",  int'(done_b),  int'(m_mode[1] == 2));
      check("busy_b",  int'(busy_b),  int'(m_mode[1] == 1));
    end
  endtask

  initial begin
    m_mod[0] = MOD_A;
    m_mod[1] = MOD_B;

    // Reset state
    step(0, 0, 0, 0, 0);
    check("reset_count_a", int'(count_a), 3);

    // Free wrap through zero
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0);
    check("wrap_count_a", int'(count_a), 2);

    // One-shot from 2, run to completion then hold
    step(1, 0, 1, 2, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0);
    check("oneshot_done_a", int'(done_a), 1);
    check("oneshot_hold_a", int'(count_a), 0);

    // DONE ignores en, then re-arm into free mode
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0);

    // Load with en and an out-of-range value for the MOD=6 instance
    step(1, 1, 1, 7, 1);
    check("clamp_count_b", int'(count_b), 5);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    check("reset_mid_run_busy_a", int'(busy_a), 0);

    // Zero load in one-shot: single terminal cycle then done
    step(1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
